zx_mem_arbiter: RTL and testbench

ZX_MEM_ARBITER -- requirements
Module: zx_mem_arbiter

---
 rtl/zx_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_zx_mem_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zx_mem_arbiter.sv
// zx_mem_arbiter: single-port RAM arbiter, video reads vs CPU rd/wr.
// Video wins ties unless the CPU has waited MAX_WAIT cycles.
//
// Ports:
//   clk, reset           clock, async active-high reset
//   vid_req/addr         video read request (held until vid_ack)
//   vid_ack/rdata        one-cycle ack, registered read data
//   cpu_req/we/addr/     CPU request (held until cpu_ack)
//   cpu_wdata
//   cpu_ack/rdata        one-cycle ack, registered read data
//   mem_addr/wdata/we    registered RAM controls
//   mem_rdata            RAM read data
//   busy                 high whenever the FSM is not IDLE
module zx_mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int RD_LAT   = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [7:0]        vid_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE,
    VRD,
    CRD,
    CWR,
    DONE
  } state_t;

  localparam logic [2:0] LAST = 3'(RD_LAT);
  localparam logic [3:0] MW4  = 4'(MAX_WAIT);

  state_t     state;
  logic [2:0] cnt;
  logic [3:0] cpu_wait;
  logic       done_cpu;
  logic       cpu_win;
  logic       cpu_owns;

  // CPU takes the grant when alone or once it has starved long enough.
  assign cpu_win = cpu_req && (!vid_req || cpu_wait >= MW4);

  // Waiting is not counted while the CPU itself holds the RAM.
  assign cpu_owns = (state == CRD) || (state == CWR) ||
                    (state == DONE && done_cpu);

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cpu_wait  <= '0;
      done_cpu  <= 1'b0;
      vid_ack   <= 1'b0;
      cpu_ack   <= 1'b0;
      vid_rdata <= '0;
      cpu_rdata <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else begin
      vid_ack <= 1'b0;
      cpu_ack <= 1'b0;

      if (state == IDLE && cpu_win)
        cpu_wait <= '0;
      else if (cpu_req && !cpu_owns && cpu_wait != 4'hF)
        cpu_wait <= cpu_wait + 4'd1;

      unique case (state)
        IDLE: begin
          if (cpu_win) begin
            mem_addr <= cpu_addr;
            cnt      <= '0;
            done_cpu <= 1'b1;
            if (cpu_we) begin
              mem_wdata <= cpu_wdata;
              mem_we    <= 1'b1;
              state     <= CWR;
            end else begin
              state <= CRD;
            end
          end else if (vid_req) begin
            mem_addr <= vid_addr;
            cnt      <= '0;
            done_cpu <= 1'b0;
            state    <= VRD;
          end
        end
        // cnt counts edges since the grant; RAM data is
        // valid to sample once RD_LAT edges have passed.
        VRD: begin
          if (cnt == LAST) begin
            vid_rdata <= mem_rdata;
            vid_ack   <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        CRD: begin
          if (cnt == LAST) begin
            cpu_rdata <= mem_rdata;
            cpu_ack   <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        CWR: begin
          mem_we  <= 1'b0;
          cpu_ack <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zx_mem_arbiter.sv
// tb_zx_mem_arbiter: directed + random checks of zx_mem_arbiter
// against a transaction-timing reference model.
module tb_zx_mem_arbiter;

  localparam int AW = 16;
  localparam int RL = 2;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_ack;
  logic [7:0]    vid_rdata;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic          cpu_ack;
  logic [7:0]    cpu_rdata;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_we;
  logic [7:0]    mem_rdata;
  logic          busy;

  always #5 clk = ~clk;

  zx_mem_arbiter #(
    .ADDR_W  (AW),
    .RD_LAT  (RL),
    .MAX_WAIT(MW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .vid_req  (vid_req),
    .vid_addr (vid_addr),
    .vid_ack  (vid_ack),
    .vid_rdata(vid_rdata),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_ack  (cpu_ack),
    .cpu_rdata(cpu_rdata),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  function automatic logic [7:0] init_val(input logic [15:0] a);
    if (a == 16'h4000) return 8'hA5;
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // RAM: data appears RL cycles after mem_addr is registered.
  bit   [7:0]    ram  [0:65535];
  bit            wv   [0:65535];
  logic [AW-1:0] pipe [0:RL-1];

  assign mem_rdata = wv[pipe[RL-1]] ? ram[pipe[RL-1]]
                                    : init_val(pipe[RL-1]);

  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      wv[mem_addr]  <= 1'b1;
    end
    pipe[0] <= mem_addr;
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end

  // Reference model: each transaction is a span of edges.
  int            n;
  int            g_edge, ack_edge, end_edge, wt;
  bit            own_cpu, is_wr;
  logic [7:0]    t_data;
  logic [7:0]    shadow [int];
  logic          e_vack, e_cack, e_busy, e_we;
  logic [7:0]    e_vrd, e_crd, e_mwd;
  logic [AW-1:0] e_maddr;

  int errs   = 0;
  int checks = 0;
  bit v_hold = 1'b0;
  bit c_hold = 1'b0;

  task automatic model_reset();
    g_edge   = -100;
    ack_edge = -100;
    end_edge = -100;
    wt       = 0;
    own_cpu  = 1'b0;
    is_wr    = 1'b0;
    e_vack   = 1'b0;
    e_cack   = 1'b0;
    e_busy   = 1'b0;
    e_we     = 1'b0;
    e_vrd    = '0;
    e_crd    = '0;
    e_mwd    = '0;
    e_maddr  = '0;
  endtask

  task automatic grant(input bit cpu, input bit wr,
                       input logic [15:0] a, input logic [7:0] d);
    own_cpu  = cpu;
    is_wr    = wr;
    g_edge   = n;
    ack_edge = n + (wr ? 1 : RL + 1);
    end_edge = ack_edge + 1;
    e_maddr  = a;
    if (wr) begin
      e_mwd     = d;
      shadow[a] = d;
      t_data    = d;
    end else begin
      t_data = shadow.exists(a) ? shadow[a] : init_val(a);
    end
  endtask

  // Predict outputs after the coming posedge from current inputs.
  task automatic model_edge();
    n++;
    if (n > end_edge) begin
      if (cpu_req && (!vid_req || wt >= MW)) begin
        grant(1'b1, cpu_we, cpu_addr, cpu_wdata);
        wt = 0;
      end else begin
        if (vid_req) grant(1'b0, 1'b0, vid_addr, 8'h00);
        if (cpu_req && wt < 15) wt++;
      end
    end else if (!own_cpu && cpu_req && wt < 15) begin
      wt++;
    end
    e_busy = (n >= g_edge) && (n < end_edge);
    e_vack = (n == ack_edge) && !own_cpu;
    e_cack = (n == ack_edge) && own_cpu;
    e_we   = (n == g_edge) && is_wr;
    if (n == ack_edge && !is_wr) begin
      if (own_cpu) e_crd = t_data;
      else         e_vrd = t_data;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("vid_ack",   32'(vid_ack),   32'(e_vack));
    chk("cpu_ack",   32'(cpu_ack),   32'(e_cack));
    chk("busy",      32'(busy),      32'(e_busy));
    chk("mem_we",    32'(mem_we),    32'(e_we));
    chk("vid_rdata", 32'(vid_rdata), 32'(e_vrd));
    chk("cpu_rdata", 32'(cpu_rdata), 32'(e_crd));
    chk("mem_addr",  32'(mem_addr),  32'(e_maddr));
    chk("mem_wdata", 32'(mem_wdata), 32'(e_mwd));
    chk("ack_overlap", 32'(vid_ack & cpu_ack), 32'd0);
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all();
    if (e_vack && !v_hold) vid_req = 1'b0;
    if (e_cack && !c_hold) cpu_req = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    n++;
    @(negedge clk);
    check_all();
    reset = 1'b0;
  endtask

  int lat, cnt, first, gap, k;
  bit bsy;
  int seq [8];

  initial begin
    reset     = 1'b1;
    vid_req   = 1'b0;
    vid_addr  = '0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    n         = 0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    reset = 1'b0;

    // Video read of 4000.
    vid_addr = 16'h4000;
    vid_req  = 1'b1;
    lat = -1;
    bsy = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cycle();
      if (lat > 0 && i == lat + 1) bsy = busy;
      if (vid_ack && lat < 0) lat = i;
    end
    chk("vrd_latency", 32'(lat - 1), 32'd3);
    chk("vrd_data", 32'(vid_rdata), 32'hA5);
    chk("vrd_busy_after", 32'(bsy), 32'd0);

    // CPU write then read back.
    cpu_we    = 1'b1;
    cpu_addr  = 16'h8001;
    cpu_wdata = 8'h3C;
    cpu_req   = 1'b1;
    lat = -1;
    cnt = 0;
    for (int i = 1; i <= 6; i++) begin
      cycle();
      if (mem_we) cnt++;
      if (cpu_ack && lat < 0) lat = i;
    end
    chk("cwr_we_cycles", 32'(cnt), 32'd1);
    chk("cwr_latency", 32'(lat - 1), 32'd1);
    cpu_we  = 1'b0;
    cpu_req = 1'b1;
    for (int i = 1; i <= 8; i++) cycle();
    chk("crd_data", 32'(cpu_rdata), 32'h3C);

    // Contention with both requests held.
    v_hold  = 1'b1;
    c_hold  = 1'b1;
    vid_req = 1'b1;
    cpu_req = 1'b1;
    k = 0;
    for (int i = 0; i < 8; i++) seq[i] = 9;
    for (int i = 1; i <= 24; i++) begin
      cycle();
      if (vid_ack && k < 8) begin seq[k] = 0; k++; end
      if (cpu_ack && k < 8) begin seq[k] = 1; k++; end
    end
    chk("cont_acks", 32'(k), 32'd5);
    chk("cont_0_vid", 32'(seq[0]), 32'd0);
    chk("cont_1_cpu", 32'(seq[1]), 32'd1);
    chk("cont_2_vid", 32'(seq[2]), 32'd0);
    chk("cont_3_cpu", 32'(seq[3]), 32'd1);
    v_hold = 1'b0;
    c_hold = 1'b0;
    for (int i = 1; i <= 12; i++) cycle();

    // Reset one cycle into a video read; request held across it.
    vid_addr = 16'h4000;
    vid_req  = 1'b1;
    cycle();
    cycle();
    pulse_reset();
    chk("rst_vrdata", 32'(vid_rdata), 32'd0);
    cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      cycle();
      if (vid_ack) cnt++;
    end
    chk("rst_after_acks", 32'(cnt), 32'd1);
    chk("rst_after_data", 32'(vid_rdata), 32'hA5);

    // Video request held through two transactions.
    v_hold   = 1'b1;
    vid_addr = 16'h8003;
    vid_req  = 1'b1;
    cnt   = 0;
    first = -1;
    gap   = 0;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      if (vid_ack) begin
        cnt++;
        if (first < 0) first = i;
        else gap = i - first;
      end
    end
    vid_req = 1'b0;
    v_hold  = 1'b0;
    for (int i = 1; i <= 4; i++) cycle();
    chk("hold_acks", 32'(cnt), 32'd2);
    chk("hold_gap", 32'(gap), 32'(RL + 3));

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if (!vid_req) begin
        if ($urandom_range(0, 3) == 0) begin
          vid_req  = 1'b1;
          vid_addr = {12'h800, 4'($urandom_range(0, 15))};
        end
      end else if ($urandom_range(0, 31) == 0) begin
        vid_req = 1'b0;
      end
      if (!cpu_req) begin
        if ($urandom_range(0, 3) == 0) begin
          cpu_req   = 1'b1;
          cpu_we    = 1'($urandom_range(0, 1));
          cpu_addr  = {12'h800, 4'($urandom_range(0, 15))};
          cpu_wdata = 8'($urandom);
        end
      end else if ($urandom_range(0, 31) == 0) begin
        cpu_req = 1'b0;
      end
      v_hold = ($urandom_range(0, 3) == 0);
      c_hold = ($urandom_range(0, 3) == 0);
      cycle();
    end
    v_hold  = 1'b0;
    c_hold  = 1'b0;
    vid_req = 1'b0;
    cpu_req = 1'b0;
    for (int i = 1; i <= 8; i++) cycle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
